data_memory_arbiter: RTL

Two-requester arbiter and sequencer for `data_memory_unit` (256 × 32-bit, synchronous, one-cycle registered read). It accepts read/write commands from two masters, such as the load/store path and a DMA/debug port, over valid/ready handshakes. It grants the shared memory round-robin, drives the memory's `en`/`wen`/`addr`/`data_in` pins, and returns read data or a write acknowledge to the granted master. It sits between the masters and the single `data_memory_unit` instance and is that memory's only driver.

---
 rtl/data_memory_arbiter_pkg.sv | 32 +++
 rtl/data_memory_arbiter_if.sv | 32 +++
 rtl/data_memory_arbiter_rr.sv | 39 +++
 rtl/data_memory_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and sizes for the data memory arbiter: widths, FSM states,
// the registered memory command and a small id-to-one-hot helper.
package data_memory_arbiter_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RWAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Convert a requester id into its response/grant bit position
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
        logic [NUM_REQ-1:0] onehot;
        if (id) begin
            onehot = 2'b10;
        end else begin
            onehot = 2'b01;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two-master request/response bus and the memory pin bus.
// The slave side is the arbiter; the master side is whoever drives the
// requests and models the memory's read port.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                mem_en;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_memory_arbiter_rr.sv
// Combinational two-way round-robin picker. A lone requester always wins;
// on a tie the requester that was not granted last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Select the winner from the request vector and the previous grant
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                if (last_grant) begin
                    gnt    = 2'b01;
                    gnt_id = 1'b0;
                end else begin
                    gnt    = 2'b10;
                    gnt_id = 1'b1;
                end
            end
            default: begin
                gnt    = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbiter and sequencer in front of the single-port data memory. Accepts one
// command at a time from two masters, strobes the memory for one cycle and
// returns a one-cycle response pulse (with read data for reads).
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    data_memory_arbiter_if.slave        bus,
    output logic                        busy
);

    arb_state_t        state_r;
    arb_state_t        state_s;
    mem_cmd_t          cmd_r;
    mem_cmd_t          cmd_s;
    logic              mem_en_r;
    logic              id_r;
    logic              last_grant_r;
    logic [1:0]        gnt_s;
    logic              gnt_id_s;
    logic              accept_s;
    logic [1:0]        ready_s;
    logic [1:0]        rsp_valid_s;
    logic [1:0]        rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              busy_r;

    rr_arbiter2 u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant_r),
        .gnt        (gnt_s),
        .gnt_id     (gnt_id_s)
    );

    // Gather the winning master's command fields
    always_comb begin
        cmd_s = '0;
        if (gnt_id_s) begin
            cmd_s.we    = bus.req_we[1];
            cmd_s.addr  = bus.req_addr[2*ADDR_W-1:ADDR_W];
            cmd_s.wdata = bus.req_wdata[2*DATA_W-1:DATA_W];
        end else begin
            cmd_s.we    = bus.req_we[0];
            cmd_s.addr  = bus.req_addr[ADDR_W-1:0];
            cmd_s.wdata = bus.req_wdata[DATA_W-1:0];
        end
    end

    // Next-state, ready and response-pulse decode
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        ready_s     = 2'b00;
        rsp_valid_s = 2'b00;
        case (state_r)
            ARB_IDLE: begin
                ready_s = gnt_s;
                if (gnt_s != 2'b00) begin
                    accept_s = 1'b1;
                    state_s  = ARB_ISSUE;
                end else begin
                    state_s  = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (cmd_r.we) begin
                    rsp_valid_s = id_to_onehot(id_r);
                    state_s     = ARB_IDLE;
                end else begin
                    state_s     = ARB_RWAIT;
                end
            end
            ARB_RWAIT: begin
                rsp_valid_s = id_to_onehot(id_r);
                state_s     = ARB_IDLE;
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    // FSM state and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ARB_IDLE);
        end
    end

    // Command register: holds the accepted command only for the ISSUE cycle
    // so the memory pins read back as zero in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r    <= '0;
            mem_en_r <= 1'b0;
        end else if (accept_s) begin
            cmd_r    <= cmd_s;
            mem_en_r <= 1'b1;
        end else begin
            cmd_r    <= '0;
            mem_en_r <= 1'b0;
        end
    end

    // Granted id and round-robin history, updated on accept only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            id_r         <= gnt_id_s;
            last_grant_r <= gnt_id_s;
        end else begin
            id_r         <= id_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Response pulse and read-data capture; data holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 2'b00;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= rsp_valid_s;
            if (state_r == ARB_RWAIT) begin
                rsp_rdata_r <= bus.mem_rdata;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_wen   = cmd_r.we;
    assign bus.mem_addr  = cmd_r.addr;
    assign bus.mem_wdata = cmd_r.wdata;
    assign busy          = busy_r;

endmodule
